// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver and its receive FIFO.
//   UART_DATA_WIDTH      : width of one received byte
//   UART_FIFO_ADDR_WIDTH : receive FIFO address width (depth = 2**width)
package uart_pkg;

   localparam int UART_DATA_WIDTH      = 8;
   localparam int UART_FIFO_ADDR_WIDTH = 4;

   // Number of FIFO entries for a given address width.
   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: storage array for the UART receive FIFO.
// One synchronous write port and one asynchronous read port. Contents are not reset.
//   clk     : rising-edge clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data, combinational from rd_addr
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO behind the UART receiver.
// Optional feature: define UART_RX_FIFO_OVERFLOW_EN to compile in the sticky overflow flag;
// without it o_overflow is tied 0 (bytes written while full are still dropped).
//   clk, reset     : clock and synchronous active-high reset
//   i_wr/i_wr_data : write strobe and byte from the receiver
//   o_rd_valid     : head entry present
//   i_rd_ready     : consumer takes the head entry
//   o_rd_data      : head entry (zero read latency)
//   o_full/o_empty : derived from o_count
//   o_count        : number of stored entries, 0..depth
//   o_overflow     : sticky, a write was dropped; i_clr_overflow clears it
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_rd_valid,
   input  logic                  i_rd_ready,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_overflow,
   input  logic                  i_clr_overflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(fifo_depth(ADDR_WIDTH));

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  push;
   logic                  pop;
   logic                  drop;

   // Status comes from the count so pointer wrap never glitches full/empty.
   assign o_count    = count;
   assign o_full     = (count == DEPTH);
   assign o_empty    = (count == '0);
   assign o_rd_valid = ~o_empty;

   assign pop  = o_rd_valid & i_rd_ready;
   // A pop in the same cycle frees the slot, so a write while full is accepted.
   assign push = i_wr & (~o_full | pop);
   assign drop = i_wr & ~push;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

`ifdef UART_RX_FIFO_OVERFLOW_EN
   logic overflow;

   // Set wins over clear when both happen in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (i_clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   assign o_overflow = overflow;
`else
   logic unused_ovf;
   assign unused_ovf = i_clr_overflow ^ drop;
   assign o_overflow = 1'b0;
`endif

   uart_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .we      (push),
      .wr_addr (wr_ptr),
      .wr_data (i_wr_data),
      .rd_addr (rd_ptr),
      .rd_data (o_rd_data)
   );

endmodule
